hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and flow controller that drives the write-enable, flush and bubble controls of the fetch/decode and decode/execute pipeline registers. It stalls on load-use hazards, squashes wrong-path instructions on taken branches, and freezes the whole pipe while data memory is busy. It also drains the pipe after a halt and then holds the core halted. It sits beside the decode stage and consumes the EX-stage decode signals registered by the decode/execute register.

## Interface
- DRAIN_CYCLES, 3: cycles spent draining older instructions (EX, MEM, WB) after a halt leaves ID; legal range 1..15.
- CNT_W, 16: width of the stall counter.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs  in  4  first source register of the ID instruction.
- id_rt  in  4  second source register of the ID instruction.
- id_rs_used  in  1  the ID instruction reads id_rs.
- id_rt_used  in  1  the ID instruction reads id_rt.
- id_hlt  in  1  the ID instruction is a halt.
- ex_lw  in  1  the EX instruction is a load.
- ex_rd  in  4  destination register of the EX instruction.
- ex_branch_taken  in  1  the EX instruction is a branch or jump resolved as taken.
- mem_busy  in  1  data memory is not ready; the pipe must freeze.
- pc_wen  out  1  PC register write enable.
- ifid_wen  out  1  fetch/decode register write enable.
- idex_wen  out  1  decode/execute register write enable.
- ifid_flush  out  1  load a nop into the fetch/decode register.
- idex_bubble  out  1  load a nop into the decode/execute register (all D_* signals 0).
- halted  out  1  core halted.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- State machine with three states: RUN, DRAIN, HALTED. A 4-bit drain counter is used in DRAIN.
- Load-use hazard (lu): ex_lw & id_valid & ex_rd≠0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- In RUN, conditions are evaluated in this priority order, and only the first match applies:
  - ex_branch_taken: pc_wen=1, ifid_wen=1, idex_wen=1, ifid_flush=1, idex_bubble=1. The state stays RUN. The branch overrides lu and id_hlt because the ID instruction is wrong-path.
  - mem_busy: pc_wen=0, ifid_wen=0, idex_wen=0, no flush, no bubble.
  - lu: pc_wen=0, ifid_wen=0, idex_wen=1, idex_bubble=1.
  - id_valid & id_hlt: pc_wen=0, ifid_wen=1, ifid_flush=1, idex_wen=1 (the halt advances to EX). Next state is DRAIN, and the drain counter is loaded with DRAIN_CYCLES.
  - Otherwise: pc_wen=1, ifid_wen=1, idex_wen=1, no flush, no bubble.
- In DRAIN:
  - If mem_busy: all enables are 0 and the counter holds.
  - Otherwise: pc_wen=0, ifid_wen=1, ifid_flush=1, idex_wen=1, idex_bubble=1, and the counter decrements.
  - When the counter is 1 and not frozen, the next state is HALTED.
  - ex_branch_taken and lu are ignored in DRAIN.
- In HALTED: all enables, ifid_flush and idex_bubble are 0, and halted=1. HALTED is left only by reset.
- stall_count increments by 1 on every clock edge in RUN where pc_wen=0 because of mem_busy or lu, and on every edge in DRAIN where mem_busy=1. It saturates at all-ones and does not wrap.

## Timing
- All enable, flush and bubble outputs are combinational from the current state and the current inputs. halted is decoded from the registered state.
- Reset (rst=0), asynchronous: state goes to RUN, the drain counter to 0, and stall_count to 0. While rst=0, every output is 0.
- First cycle after rst rises: RUN behaviour.
- Load-use costs exactly 1 bubble cycle. On the next cycle ex_lw=0 because of the bubble, so lu clears unless new inputs recreate it.
- Taken branch costs 2 squashed instructions: the one in IF and the one in ID, in the same cycle the branch is in EX.
- Halt: if the halt is in ID in RUN at cycle N, DRAIN covers cycles N+1..N+DRAIN_CYCLES (plus any mem_busy cycles), and halted=1 from cycle N+DRAIN_CYCLES+1.
- mem_busy extends any state one cycle per busy cycle. There is no state change and no counter change while busy, except stall_count.

## Test plan
- Load-use: ex_lw=1, ex_rd=3, id_rs=3, id_rs_used=1, id_valid=1 for 1 cycle → that cycle pc_wen=0, ifid_wen=0, idex_wen=1, idex_bubble=1, and stall_count goes 0→1. Repeat with ex_rd=0 → no stall.
- Branch over hazard: ex_branch_taken=1 together with the load-use inputs above and id_hlt=1 → pc_wen=1, ifid_flush=1, idex_bubble=1, the state stays RUN, and stall_count is unchanged.
- Memory freeze: mem_busy=1 for 4 cycles in RUN → all enables 0 for those 4 cycles and stall_count=4. After release → normal enables.
- Halt drain: id_hlt=1, id_valid=1 at cycle 10 with DRAIN_CYCLES=3 → ifid_flush=1 in cycles 10..13, halted=1 from cycle 14, all enables 0 thereafter. The same scenario with mem_busy=1 in cycle 12 → halted from cycle 15.
- Saturation: force 70000 load-use cycles with CNT_W=16 → stall_count holds at 0xFFFF.
- Reset mid-drain: assert rst=0 asynchronously in DRAIN cycle 2 → outputs go to 0 immediately. After release: RUN, halted=0, stall_count=0, pc_wen=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and flow controller for the IF/ID and ID/EX pipeline registers.
// It handles load-use stalls, taken-branch squashes, memory freezes and the halt drain sequence.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_hlt,
    input  logic             ex_lw,
    input  logic [3:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_drain_cnt;
    logic [3:0]       w_next_drain_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_lu;
    logic             w_stall_inc;
    logic             w_pc_wen;
    logic             w_ifid_wen;
    logic             w_idex_wen;
    logic             w_ifid_flush;
    logic             w_idex_bubble;

    assign w_lu = ex_lw && id_valid && (ex_rd != 4'd0) &&
                  ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_next_state     = r_state;
        w_next_drain_cnt = r_drain_cnt;
        w_stall_inc      = 1'b0;
        w_pc_wen         = 1'b0;
        w_ifid_wen       = 1'b0;
        w_idex_wen       = 1'b0;
        w_ifid_flush     = 1'b0;
        w_idex_bubble    = 1'b0;

        case (r_state)
            S_RUN: begin
                // The branch wins over everything: the ID instruction is wrong-path.
                if (ex_branch_taken) begin
                    w_pc_wen      = 1'b1;
                    w_ifid_wen    = 1'b1;
                    w_idex_wen    = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else if (mem_busy) begin
                    w_stall_inc = 1'b1;
                end else if (w_lu) begin
                    w_idex_wen    = 1'b1;
                    w_idex_bubble = 1'b1;
                    w_stall_inc   = 1'b1;
                end else if (id_valid && id_hlt) begin
                    w_ifid_wen       = 1'b1;
                    w_ifid_flush     = 1'b1;
                    w_idex_wen       = 1'b1;
                    w_next_state     = S_DRAIN;
                    w_next_drain_cnt = 4'(DRAIN_CYCLES);
                end else begin
                    w_pc_wen   = 1'b1;
                    w_ifid_wen = 1'b1;
                    w_idex_wen = 1'b1;
                end
            end
            S_DRAIN: begin
                if (mem_busy) begin
                    w_stall_inc = 1'b1;
                end else begin
                    w_ifid_wen       = 1'b1;
                    w_ifid_flush     = 1'b1;
                    w_idex_wen       = 1'b1;
                    w_idex_bubble    = 1'b1;
                    w_next_drain_cnt = r_drain_cnt - 4'd1;
                    if (r_drain_cnt == 4'd1) begin
                        w_next_state = S_HALTED;
                    end
                end
            end
            default: begin
                w_next_state = S_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state       <= S_RUN;
            r_drain_cnt   <= 4'd0;
            r_stall_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain_cnt;
            if (w_stall_inc && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    // Controls are combinational, so they are gated while reset is held low.
    assign pc_wen      = rst & w_pc_wen;
    assign ifid_wen    = rst & w_ifid_wen;
    assign idex_wen    = rst & w_idex_wen;
    assign ifid_flush  = rst & w_ifid_flush;
    assign idex_bubble = rst & w_idex_bubble;
    assign halted      = (r_state == S_HALTED);
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expected values.
// Control outputs are packed as {pc_wen, ifid_wen, idex_wen, ifid_flush, idex_bubble}.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_hlt;
    logic        ex_lw;
    logic [3:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_busy;
    logic        pc_wen;
    logic        ifid_wen;
    logic        idex_wen;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [15:0] stall_count;
    logic [4:0]  ctl;

    int n_total;
    int n_pass;

    localparam logic [4:0] C_ZERO  = 5'b00000;
    localparam logic [4:0] C_RUN   = 5'b11100;
    localparam logic [4:0] C_LU    = 5'b00101;
    localparam logic [4:0] C_BR    = 5'b11111;
    localparam logic [4:0] C_HLT   = 5'b01110;
    localparam logic [4:0] C_DRAIN = 5'b01111;

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rs_used      (id_rs_used),
        .id_rt_used      (id_rt_used),
        .id_hlt          (id_hlt),
        .ex_lw           (ex_lw),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_wen          (pc_wen),
        .ifid_wen        (ifid_wen),
        .idex_wen        (idex_wen),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    assign ctl = {pc_wen, ifid_wen, idex_wen, ifid_flush, idex_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [3:0] rs, input logic rsu,
                          input logic [3:0] rt, input logic rtu, input logic hlt,
                          input logic lw, input logic [3:0] rd, input logic br,
                          input logic busy);
        id_valid        = v;
        id_rs           = rs;
        id_rs_used      = rsu;
        id_rt           = rt;
        id_rt_used      = rtu;
        id_hlt          = hlt;
        ex_lw           = lw;
        ex_rd           = rd;
        ex_branch_taken = br;
        mem_busy        = busy;
        #1;
    endtask

    task automatic idle();
        set_in(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic lu_in();
        set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    endtask

    task automatic halt_in();
        set_in(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b0;
        idle();
        #2;
        check("reset_ctl", 32'(ctl), 32'(C_ZERO));
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        idle();
        check("run_ctl", 32'(ctl), 32'(C_RUN));
        tick();

        lu_in();
        check("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        tick();
        check("lu_rs_count", 32'(stall_count), 32'd1);

        set_in(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        check("lu_r0_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        check("lu_r0_count", 32'(stall_count), 32'd1);

        set_in(1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        check("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        tick();
        check("lu_rt_count", 32'(stall_count), 32'd2);

        set_in(1'b1, 4'd4, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        check("lu_rt_unused_ctl", 32'(ctl), 32'(C_RUN));
        tick();

        set_in(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        check("lu_invalid_ctl", 32'(ctl), 32'(C_RUN));
        tick();

        set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        check("br_ctl", 32'(ctl), 32'(C_BR));
        tick();
        check("br_count", 32'(stall_count), 32'd2);
        idle();
        check("br_stays_run", 32'(ctl), 32'(C_RUN));
        tick();

        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
            check($sformatf("busy_ctl_%0d", i), 32'(ctl), 32'(C_ZERO));
            tick();
        end
        check("busy_count", 32'(stall_count), 32'd6);
        idle();
        check("busy_release_ctl", 32'(ctl), 32'(C_RUN));
        tick();

        set_in(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("br_over_busy_ctl", 32'(ctl), 32'(C_BR));
        tick();
        check("br_over_busy_count", 32'(stall_count), 32'd6);

        halt_in();
        check("halt_ctl", 32'(ctl), 32'(C_HLT));
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
            check($sformatf("drain_ctl_%0d", i), 32'(ctl), 32'(C_DRAIN));
            check($sformatf("drain_halted_%0d", i), 32'(halted), 32'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            check($sformatf("halted_%0d", i), 32'(halted), 32'd1);
            check($sformatf("halted_ctl_%0d", i), 32'(ctl), 32'(C_ZERO));
            tick();
        end
        check("halt_count", 32'(stall_count), 32'd6);

        do_reset();
        check("rst2_halted", 32'(halted), 32'd0);
        halt_in();
        check("hb_halt_ctl", 32'(ctl), 32'(C_HLT));
        tick();
        idle();
        check("hb_d1_ctl", 32'(ctl), 32'(C_DRAIN));
        tick();
        set_in(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("hb_busy_ctl", 32'(ctl), 32'(C_ZERO));
        tick();
        check("hb_busy_count", 32'(stall_count), 32'd1);
        idle();
        check("hb_d2_ctl", 32'(ctl), 32'(C_DRAIN));
        tick();
        check("hb_d3_ctl", 32'(ctl), 32'(C_DRAIN));
        check("hb_d3_halted", 32'(halted), 32'd0);
        tick();
        check("hb_halted", 32'(halted), 32'd1);
        check("hb_halted_ctl", 32'(ctl), 32'(C_ZERO));

        do_reset();
        lu_in();
        tick();
        check("md_pre_count", 32'(stall_count), 32'd1);
        halt_in();
        tick();
        idle();
        tick();
        rst = 1'b0;
        #1;
        check("md_async_ctl", 32'(ctl), 32'(C_ZERO));
        check("md_async_count", 32'(stall_count), 32'd0);
        check("md_async_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("md_after_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        check("md_after_halted", 32'(halted), 32'd0);
        check("md_after_count", 32'(stall_count), 32'd0);

        lu_in();
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        check("sat_count", 32'(stall_count), 32'h0000_FFFF);
        check("sat_ctl", 32'(ctl), 32'(C_LU));
        tick();
        check("sat_hold", 32'(stall_count), 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
